// File: rtl/control_sequencer_pkg.sv
// SAP microsequencer shared definitions: opcodes, one-hot T-state codes, ALU selects.
package sap_ctrl_pkg;

    localparam int OPC_W    = 4;
    localparam int T_STATES = 6;

    localparam logic [OPC_W-1:0] OP_LDA  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_AND  = 4'b0011;
    localparam logic [OPC_W-1:0] OP_OR   = 4'b0100;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'b0101;
    localparam logic [OPC_W-1:0] OP_XNOR = 4'b0110;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'b1110;
    localparam logic [OPC_W-1:0] OP_HLT  = 4'b1111;

    localparam logic [T_STATES-1:0] T1 = 6'b000001;
    localparam logic [T_STATES-1:0] T2 = 6'b000010;
    localparam logic [T_STATES-1:0] T3 = 6'b000100;
    localparam logic [T_STATES-1:0] T4 = 6'b001000;
    localparam logic [T_STATES-1:0] T5 = 6'b010000;
    localparam logic [T_STATES-1:0] T6 = 6'b100000;

    localparam logic [1:0] SEL_SUM = 2'b00;
    localparam logic [1:0] SEL_AND = 2'b01;
    localparam logic [1:0] SEL_OR  = 2'b10;
    localparam logic [1:0] SEL_XN  = 2'b11;

    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_XNOR);
    endfunction

    function automatic logic is_nop(input logic [OPC_W-1:0] op);
        return !(op == OP_LDA || is_alu(op) || op == OP_OUT || op == OP_HLT);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Opcode in, T-state / control word / halt out between sequencer and datapath.
interface control_sequencer_if;
    import sap_ctrl_pkg::*;

    logic [OPC_W-1:0]    opcode;
    logic [T_STATES-1:0] t_state;
    logic pc_out, pc_inc, mar_in, ram_out, ir_in, ir_out;
    logic br_in, br_out, acc_in, acc_out, alu_out, out_in;
    logic add_sub, xn;
    logic [1:0] S;
    logic halt;

    modport master (
        input  opcode,
        output t_state, pc_out, pc_inc, mar_in, ram_out, ir_in, ir_out,
               br_in, br_out, acc_in, acc_out, alu_out, out_in,
               add_sub, xn, S, halt
    );

    modport slave (
        output opcode,
        input  t_state, pc_out, pc_inc, mar_in, ram_out, ir_in, ir_out,
               br_in, br_out, acc_in, acc_out, alu_out, out_in,
               add_sub, xn, S, halt
    );

endinterface

// File: rtl/control_sequencer_ring_counter.sv
// One-hot T-state ring: sync reset to T1, hold freezes, restart forces T1 next.
module ring_counter
    import sap_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                cls_i,
    input  logic                hold_i,
    input  logic                restart_i,
    output logic [T_STATES-1:0] t_state_o
);

    logic [T_STATES-1:0] state_q, state_d;

    always_ff @(posedge clk) begin
        if (cls_i) state_q <= T1;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (hold_i)         state_d = state_q;
        else if (restart_i) state_d = T1;
        else                state_d = {state_q[T_STATES-2:0], state_q[T_STATES-1]};
    end

    assign t_state_o = state_q;

endmodule

// File: rtl/control_sequencer.sv
// SAP microsequencer: T-state ring plus Moore opcode decoder driving bus/ALU controls.
// Build option VARIABLE_RING_EN: ring restarts after the last active state of LDA/OUT/NOP.
module control_sequencer
    import sap_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 cls,
    control_sequencer_if.master  bus
);

    logic halt_q, halt_d;
    logic hlt_now, restart;
    logic [T_STATES-1:0] t;
    logic [OPC_W-1:0]    op;

    assign t  = bus.t_state;
    assign op = bus.opcode;

    // Halt is taken on the T4 edge itself so the ring never leaves T4.
    assign hlt_now = !halt_q && (t == T4) && (op == OP_HLT);
    assign halt_d  = halt_q | hlt_now;

    always_ff @(posedge clk) begin
        if (cls) halt_q <= 1'b0;
        else     halt_q <= halt_d;
    end

`ifdef VARIABLE_RING_EN
    assign restart = ((t == T5) && (op == OP_LDA)) ||
                     ((t == T4) && (op == OP_OUT)) ||
                     ((t == T3) && is_nop(op));
`else
    assign restart = 1'b0;
`endif

    ring_counter u_ring (
        .clk       (clk),
        .cls_i     (cls),
        .hold_i    (halt_d),
        .restart_i (restart),
        .t_state_o (bus.t_state)
    );

    assign bus.halt = halt_q;

    always_comb begin
        bus.pc_out  = 1'b0;  bus.pc_inc  = 1'b0;  bus.mar_in = 1'b0;
        bus.ram_out = 1'b0;  bus.ir_in   = 1'b0;  bus.ir_out = 1'b0;
        bus.br_in   = 1'b0;  bus.br_out  = 1'b0;  bus.acc_in = 1'b0;
        bus.acc_out = 1'b0;  bus.alu_out = 1'b0;  bus.out_in = 1'b0;
        bus.add_sub = 1'b0;  bus.xn      = 1'b0;  bus.S      = SEL_SUM;
        if (!halt_q) begin
            case (t)
                T1: begin bus.pc_out = 1'b1; bus.mar_in = 1'b1; end
                T2: bus.pc_inc = 1'b1;
                T3: begin bus.ram_out = 1'b1; bus.ir_in = 1'b1; end
                T4: begin
                    if (op == OP_LDA || is_alu(op)) begin
                        bus.ir_out = 1'b1; bus.mar_in = 1'b1;
                    end else if (op == OP_OUT) begin
                        bus.acc_out = 1'b1; bus.out_in = 1'b1;
                    end
                end
                T5: begin
                    if (op == OP_LDA) begin
                        bus.ram_out = 1'b1; bus.acc_in = 1'b1;
                    end else if (is_alu(op)) begin
                        bus.ram_out = 1'b1; bus.br_in = 1'b1;
                    end
                end
                T6: begin
                    if (is_alu(op)) begin
                        bus.alu_out = 1'b1; bus.acc_in = 1'b1;
                        case (op)
                            OP_SUB:  bus.add_sub = 1'b1;
                            OP_AND:  bus.S = SEL_AND;
                            OP_OR:   bus.S = SEL_OR;
                            OP_XOR:  bus.S = SEL_XN;
                            OP_XNOR: begin bus.S = SEL_XN; bus.xn = 1'b1; end
                            default: bus.S = SEL_SUM;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against a step/table reference model.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic cls;
    int   checks = 0;
    int   failures = 0;
    int   m_step;
    bit   m_halt;
    bit   started = 0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .cls (cls),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction length in T-states as seen by the model.
    function automatic int last_step(input logic [3:0] op);
`ifdef VARIABLE_RING_EN
        case (op)
            4'd0:                               return 5;
            4'd14:                              return 4;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15: return 6;
            default:                            return 3;
        endcase
`else
        return 6;
`endif
    endfunction

    // Expected word {pc_out,pc_inc,mar_in,ram_out,ir_in,ir_out,br_in,br_out,acc_in,acc_out,alu_out,out_in,add_sub,xn,S}
    function automatic logic [15:0] exp_word(input logic [3:0] op, input int step, input bit halted);
        logic pco, pci, mi, ro, ii, io, bi, bo, ai, ao, alo, oi, as, x;
        logic [1:0] s;
        bit alu;
        {pco, pci, mi, ro, ii, io, bi, bo, ai, ao, alo, oi, as, x} = '0;
        s   = 2'b00;
        alu = (op >= 4'd1 && op <= 4'd6);
        if (!halted) begin
            if (step == 1) begin pco = 1; mi = 1; end
            if (step == 2) pci = 1;
            if (step == 3) begin ro = 1; ii = 1; end
            if (step == 4 && (op == 4'd0 || alu)) begin io = 1; mi = 1; end
            if (step == 4 && op == 4'd14) begin ao = 1; oi = 1; end
            if (step == 5 && op == 4'd0) begin ro = 1; ai = 1; end
            if (step == 5 && alu) begin ro = 1; bi = 1; end
            if (step == 6 && alu) begin
                alo = 1; ai = 1;
                if (op == 4'd2) as = 1;
                if (op == 4'd3) s = 2'b01;
                if (op == 4'd4) s = 2'b10;
                if (op == 4'd5 || op == 4'd6) s = 2'b11;
                if (op == 4'd6) x = 1;
            end
        end
        return {pco, pci, mi, ro, ii, io, bi, bo, ai, ao, alo, oi, as, x, s};
    endfunction

    function automatic logic [15:0] obs_word();
        return {bus.pc_out, bus.pc_inc, bus.mar_in, bus.ram_out, bus.ir_in, bus.ir_out,
                bus.br_in, bus.br_out, bus.acc_in, bus.acc_out, bus.alu_out, bus.out_in,
                bus.add_sub, bus.xn, bus.S};
    endfunction

    function automatic logic [5:0] exp_t();
        logic [5:0] one;
        one = 6'b000001;
        return one << (m_step - 1);
    endfunction

    // Drive inputs for one edge and advance the model alongside the DUT.
    task automatic tick(input logic c, input logic [3:0] op);
        int  n_step;
        bit  n_halt;
        cls = c;
        bus.opcode = op;
        n_step = m_step;
        n_halt = m_halt;
        if (c) begin n_step = 1; n_halt = 0; end
        else if (m_halt) ;
        else if (m_step == 4 && op == 4'd15) n_halt = 1;
        else if (m_step >= last_step(op)) n_step = 1;
        else n_step = m_step + 1;
        @(posedge clk);
        m_step = n_step;
        m_halt = n_halt;
        @(negedge clk);
    endtask

    // At most one bus driver in any cycle.
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ($countones({bus.pc_out, bus.ir_out, bus.br_out, bus.acc_out, bus.alu_out, bus.ram_out}) > 1) begin
                failures++;
                $display("FAIL bus_excl t=%0t drivers pc=%b ir=%b br=%b acc=%b alu=%b ram=%b required <=1",
                         $time, bus.pc_out, bus.ir_out, bus.br_out, bus.acc_out, bus.alu_out, bus.ram_out);
            end
        end
    end

    task automatic test_reset();
        tick(1'b1, 4'd0);
        started = 1;
        checks++;
        if (bus.t_state !== 6'b000001 || bus.halt !== 1'b0 || obs_word() !== exp_word(4'd0, 1, 0)) begin
            failures++;
            $display("FAIL reset t_state=%b halt=%b ctl=%h required 000001/0/%h",
                     bus.t_state, bus.halt, obs_word(), exp_word(4'd0, 1, 0));
        end
    endtask

    task automatic test_run(input string name, input logic [3:0] op, input int n);
        tick(1'b1, op);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, op);
            checks++;
            if (bus.t_state !== exp_t() || bus.halt !== m_halt || obs_word() !== exp_word(op, m_step, m_halt)) begin
                failures++;
                $display("FAIL %s cyc%0d t_state=%b/%b halt=%b/%b ctl=%h/%h", name, i,
                         bus.t_state, exp_t(), bus.halt, m_halt, obs_word(), exp_word(op, m_step, m_halt));
            end
        end
    endtask

    task automatic test_alu();
        logic [3:0] ops [6];
        ops = '{4'd2, 4'd6, 4'd4, 4'd1, 4'd3, 4'd5};
        foreach (ops[k]) test_run("alu", ops[k], 7);
    endtask

    task automatic test_halt();
        tick(1'b1, 4'd15);
        for (int i = 0; i < 25; i++) begin
            tick(1'b0, 4'd15);
            checks++;
            if (bus.t_state !== exp_t() || bus.halt !== m_halt || obs_word() !== exp_word(4'd15, m_step, m_halt)) begin
                failures++;
                $display("FAIL halt cyc%0d t_state=%b/%b halt=%b/%b ctl=%h/%h", i,
                         bus.t_state, exp_t(), bus.halt, m_halt, obs_word(), exp_word(4'd15, m_step, m_halt));
            end
        end
        tick(1'b1, 4'd15);
        checks++;
        if (bus.t_state !== 6'b000001 || bus.halt !== 1'b0) begin
            failures++;
            $display("FAIL halt_clear t_state=%b halt=%b required 000001/0", bus.t_state, bus.halt);
        end
    endtask

    task automatic test_cls_mid();
        tick(1'b1, 4'd1);
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd1);
        checks++;
        if (bus.t_state !== 6'b010000 || bus.br_in !== 1'b1) begin
            failures++;
            $display("FAIL cls_mid_t5 t_state=%b br_in=%b required 010000/1", bus.t_state, bus.br_in);
        end
        tick(1'b1, 4'd1);
        checks++;
        if (bus.t_state !== 6'b000001 || bus.acc_in !== 1'b0 || bus.br_in !== 1'b0 || bus.halt !== 1'b0) begin
            failures++;
            $display("FAIL cls_mid t_state=%b acc_in=%b br_in=%b halt=%b required 000001/0/0/0",
                     bus.t_state, bus.acc_in, bus.br_in, bus.halt);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic       c;
        tick(1'b1, 4'd0);
        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 15));
            c  = ($urandom_range(0, 39) == 0);
            tick(c, op);
            checks++;
            if (bus.t_state !== exp_t() || bus.halt !== m_halt || obs_word() !== exp_word(op, m_step, m_halt)) begin
                failures++;
                $display("FAIL random cyc%0d op=%h t_state=%b/%b halt=%b/%b ctl=%h/%h", i, op,
                         bus.t_state, exp_t(), bus.halt, m_halt, obs_word(), exp_word(op, m_step, m_halt));
            end
        end
    endtask

    initial begin
        cls = 1'b1;
        bus.opcode = 4'd0;
        m_step = 1;
        m_halt = 0;
        @(negedge clk);
        test_reset();
        test_run("lda", 4'd0, 7);
        test_alu();
        test_halt();
        test_cls_mid();
        test_run("out", 4'd14, 7);
        test_run("nop", 4'd8, 7);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
